// File: rtl/aes_dec_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : aes_dec_round_ctrl
// Brief   : Iterative AES inverse cipher. One shared inverse-round datapath is
//           sequenced over NR+1 externally supplied round keys.
//           Optional abort input is enabled by defining AES_DEC_ABORT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module aes_dec_round_ctrl #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      ct_in,
  output logic              rk_req,
  output logic [KIDX_W-1:0] rk_idx,
  input  logic              rk_valid,
  input  logic [127:0]      rk_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef AES_DEC_ABORT_EN
  input  logic              abort,
`endif
  output logic [127:0]      pt_out
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ARK   = 3'd1;
  localparam logic [2:0] c_ROUND = 3'd2;
  localparam logic [2:0] c_FINAL = 3'd3;
  localparam logic [2:0] c_OUT   = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_nextState;
  logic [127:0]      r_st;
  logic [KIDX_W-1:0] r_rnd;
  logic [127:0]      w_subShift;
  logic              w_abort;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 through a short square/multiply chain.
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x14, x15, x240;
    x2   = gfMul(x, x);
    x3   = gfMul(x2, x);
    x12  = gfMul(x3, x3);
    x12  = gfMul(x12, x12);
    x14  = gfMul(x12, x2);
    x15  = gfMul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gfMul(x240, x240);
    return gfMul(x240, x14);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b} >> (8 - k);
    return d[7:0];
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] y);
    return gfInv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  // Byte index r+4c sits at [127-8*(r+4c) -: 8]; row r rotates right by r.
  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] invSubBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = invSbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
      o[119-32*c -: 8] = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
      o[111-32*c -: 8] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
      o[103-32*c -: 8] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign w_subShift = invSubBytes(invShiftRows(r_st));

`ifdef AES_DEC_ABORT_EN
  assign w_abort = abort && (r_state != c_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (w_abort) begin
      w_nextState = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:  if (in_valid) w_nextState = c_ARK;
        c_ARK:   if (rk_valid) w_nextState = c_ROUND;
        c_ROUND: if (rk_valid && (r_rnd == KIDX_W'(1))) w_nextState = c_FINAL;
        c_FINAL: if (rk_valid) w_nextState = c_OUT;
        c_OUT:   if (out_ready) w_nextState = c_IDLE;
        default: w_nextState = c_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    rk_req    = 1'b0;
    rk_idx    = '0;
    out_valid = 1'b0;
    case (r_state)
      c_IDLE:  in_ready = 1'b1;
      c_ARK,
      c_ROUND: begin
        rk_req = 1'b1;
        rk_idx = r_rnd;
      end
      c_FINAL: rk_req = 1'b1;
      c_OUT:   out_valid = 1'b1;
      default: ;
    endcase
  end

  // Key data only matters in key-requesting states; elsewhere rk_valid is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st  <= '0;
      r_rnd <= '0;
    end else if (w_abort) begin
      r_st <= '0;
    end else begin
      case (r_state)
        c_IDLE: if (in_valid) begin
          r_st  <= ct_in;
          r_rnd <= KIDX_W'(NR);
        end
        c_ARK: if (rk_valid) begin
          r_st  <= r_st ^ rk_data;
          r_rnd <= r_rnd - KIDX_W'(1);
        end
        c_ROUND: if (rk_valid) begin
          r_st  <= invMixColumns(w_subShift ^ rk_data);
          r_rnd <= r_rnd - KIDX_W'(1);
        end
        c_FINAL: if (rk_valid) r_st <= w_subShift ^ rk_data;
        default: ;
      endcase
    end
  end

  assign pt_out = r_st;

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_round_ctrl.sv
`default_nettype none
// Bench for aes_dec_round_ctrl: FIPS-197 vectors, key stalls, output backpressure,
// mid-block reset and (with AES_DEC_ABORT_EN) abort; scoreboard checks plaintext and latency.
module tb_aes_dec_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct_in;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt_out;
`ifdef AES_DEC_ABORT_EN
  logic         abort = 1'b0;
`endif

  aes_dec_round_ctrl #(.NR(10), .KIDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct_in     (ct_in),
    .rk_req    (rk_req),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef AES_DEC_ABORT_EN
    .abort     (abort),
`endif
    .pt_out    (pt_out)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct {
    logic [127:0] pt;
    int           acc;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  logic [3:0]   idxLog[$];
  logic [127:0] rkMem [0:15];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           stallN = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Key schedule model (standard AES-128 expansion)
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b} >> (8 - k);
    return d[7:0];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 0;
    for (int y = 1; y < 256; y++) if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
  endfunction

  task automatic loadKey(input logic [127:0] key);
    logic [31:0] w[0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rkMem[r] = '0;
    for (int r = 0; r <= 10; r++) rkMem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Round-key responder: optional stalls per request, junk offered when not requested.
  initial begin
    int stalls = 0;
    logic [3:0] reqIdx = 0;
    rk_valid = 1'b0;
    rk_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rk_req) begin
        if (stalls == 0) reqIdx = rk_idx;
        else chk("rk_idx_stable", 128'(rk_idx), 128'(reqIdx));
        if (stalls < stallN) begin
          rk_valid = 1'b0;
          rk_data  = {$urandom, $urandom, $urandom, $urandom};
          stalls++;
        end else begin
          rk_valid = 1'b1;
          rk_data  = rkMem[rk_idx];
          stalls   = 0;
        end
      end else begin
        stalls   = 0;
        rk_valid = 1'b1;
        rk_data  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Monitor: pops the scoreboard on each new plaintext, checks hold stability.
  initial begin
    logic         prevOv = 1'b0;
    logic         prevHs = 1'b0;
    logic [127:0] prevPt = '0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (rk_req && rk_valid) idxLog.push_back(rk_idx);
      if (out_valid && !prevOv) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: out_valid=1 pt=%h, required no output", pt_out);
        end else begin
          e = sb.pop_front();
          chk("plaintext", pt_out, e.pt);
          chk("latency", 128'(cyc - e.acc), 128'(e.lat));
        end
      end
      if (out_valid && prevOv && !prevHs) chk("pt_hold", pt_out, prevPt);
      prevOv = out_valid;
      prevHs = out_valid && out_ready;
      prevPt = pt_out;
    end
  end

  task automatic sendBlock(input logic [127:0] ct, input logic [127:0] pt, input int lat);
    int n = 0;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    ct_in    = ct;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      timeoutFail("accept");
      in_valid = 1'b0;
      return;
    end
    idxLog.delete();
    e.pt  = pt;
    e.acc = cyc;
    e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || out_valid) timeoutFail("block_done");
  endtask

  task automatic checkSeq();
    int firstBad = -1;
    for (int i = 0; i < idxLog.size(); i++)
      if (idxLog[i] !== 4'(10 - i) && firstBad < 0) firstBad = i;
    total++;
    if (idxLog.size() != 11 || firstBad >= 0) begin
      bad++;
      $display("FAIL rk_seq: got %0d handshakes, first wrong position %0d; required 11 with idx 10..0",
               idxLog.size(), firstBad);
    end
  endtask

  task automatic waitIdx(input logic [3:0] idx);
    int n = 0;
    @(negedge clk);
    while (!(rk_req && rk_idx == idx) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(rk_req && rk_idx == idx)) timeoutFail("wait_rk_idx");
  endtask

  task automatic checkIdleClean(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_pt_out"}, pt_out, '0);
    chk({tag, "_rk_req"}, 128'(rk_req), 128'(0));
    chk({tag, "_rk_idx"}, 128'(rk_idx), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    ct_in     = '0;
    out_ready = 1'b1;
    loadKey(KEY_C1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkIdleClean("reset");

    // C.1 with keys always ready
    sendBlock(CT_C1, PT_C1, 12);
    waitDone(200);
    checkSeq();

    // Appendix B vector
    loadKey(KEY_B);
    sendBlock(CT_B, PT_B, 12);
    waitDone(200);
    checkSeq();

    // Three stall cycles on every key request
    loadKey(KEY_C1);
    stallN = 3;
    sendBlock(CT_C1, PT_C1, 45);
    waitDone(400);
    checkSeq();
    stallN = 0;

    // Output backpressure with an extra block offered while busy
    out_ready = 1'b0;
    sendBlock(CT_C1, PT_C1, 12);
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) timeoutFail("out_valid_hold");
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      ct_in    = CT_C1;
      @(negedge clk);
      chk("hold_out_valid", 128'(out_valid), 128'(1));
      chk("hold_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    sendBlock(CT_C1, PT_C1, 12);
    waitDone(200);
    checkSeq();

    // Reset in the middle of ROUND
    sendBlock(CT_C1, PT_C1, 12);
    waitIdx(4'd5);
    rst = 1'b1;
    @(negedge clk);
    checkIdleClean("midreset");
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    sendBlock(CT_C1, PT_C1, 12);
    waitDone(200);
    checkSeq();

`ifdef AES_DEC_ABORT_EN
    // Abort during ROUND with a key offered in the same cycle
    sendBlock(CT_C1, PT_C1, 12);
    waitIdx(4'd7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkIdleClean("abort");
    sb.delete();
    // Abort held while idle must not block the accept
    abort = 1'b1;
    sendBlock(CT_C1, PT_C1, 12);
    abort = 1'b0;
    waitDone(200);
    checkSeq();
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
